// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU command sequencer: opcode map and FSM state encoding.
package alu_seq_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_MUL  = 4'h2;
  localparam logic [3:0] OP_DIV  = 4'h3;
  localparam logic [3:0] OP_SHL  = 4'h4;
  localparam logic [3:0] OP_SHR  = 4'h5;
  localparam logic [3:0] OP_ROL  = 4'h6;
  localparam logic [3:0] OP_ROR  = 4'h7;
  localparam logic [3:0] OP_AND  = 4'h8;
  localparam logic [3:0] OP_OR   = 4'h9;
  localparam logic [3:0] OP_XOR  = 4'hA;
  localparam logic [3:0] OP_NOR  = 4'hB;
  localparam logic [3:0] OP_NAND = 4'hC;
  localparam logic [3:0] OP_XNOR = 4'hD;
  localparam logic [3:0] OP_GT   = 4'hE;
  localparam logic [3:0] OP_EQ   = 4'hF;

  // Final opcode of a sweep; the sweep select counter stops here.
  localparam logic [3:0] OP_LAST = 4'hF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    RESP  = 2'd2
  } seq_state_t;

endpackage

// File: rtl/alu_cmd_sequencer.sv
// Initiator for the 8-bit combinational ALU: accepts a command, holds operands
// stable for a settle window, captures the result and hands it back over a
// valid/ready response channel. Sweep mode walks opcodes 0..15 on one operand pair.
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [7:0]       cmd_a,
  input  logic [7:0]       cmd_b,
  input  logic [3:0]       cmd_op,
  input  logic             cmd_sweep,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  output logic [3:0]       alu_sel,
  input  logic [7:0]       alu_out,
  input  logic             alu_carry,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [7:0]       rsp_result,
  output logic             rsp_carry,
  output logic             rsp_zero,
  output logic [3:0]       rsp_op,
  output logic             rsp_last,
  output logic             busy,
  output logic [CNT_W-1:0] txn_count
);

  // Reload value for the settle counter; DRIVE lasts SETTLE_CYCLES+1 cycles so the
  // first cycle absorbs the register-to-ALU path before the settle window counts down.
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

  seq_state_t state;
  logic       sweep_q;
  logic [3:0] settle_cnt;

  assign busy = (state != IDLE);

  // Command FSM with registered ALU drive, response capture and transaction counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      sweep_q    <= 1'b0;
      settle_cnt <= 4'd0;
      cmd_ready  <= 1'b0;
      alu_a      <= 8'h00;
      alu_b      <= 8'h00;
      alu_sel    <= 4'h0;
      rsp_valid  <= 1'b0;
      rsp_result <= 8'h00;
      rsp_carry  <= 1'b0;
      rsp_zero   <= 1'b0;
      rsp_op     <= 4'h0;
      rsp_last   <= 1'b0;
      txn_count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            alu_a      <= cmd_a;
            alu_b      <= cmd_b;
            alu_sel    <= cmd_sweep ? OP_ADD : cmd_op;
            sweep_q    <= cmd_sweep;
            settle_cnt <= SETTLE_LOAD;
            cmd_ready  <= 1'b0;
            state      <= DRIVE;
          end else begin
            cmd_ready <= 1'b1;
          end
        end

        DRIVE: begin
          if (settle_cnt == 4'd0) begin
            rsp_result <= alu_out;
            rsp_carry  <= alu_carry;
            rsp_zero   <= (alu_out == 8'h00);
            rsp_op     <= alu_sel;
            rsp_last   <= !sweep_q || (alu_sel == OP_LAST);
            rsp_valid  <= 1'b1;
            state      <= RESP;
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end

        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            txn_count <= txn_count + CNT_W'(1);
            if (sweep_q && (alu_sel != OP_LAST)) begin
              alu_sel    <= alu_sel + 4'd1;
              settle_cnt <= SETTLE_LOAD;
              state      <= DRIVE;
            end else begin
              cmd_ready <= 1'b1;
              state     <= IDLE;
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer with a behavioural ALU attached.
// Instance dut uses default parameters; dut_w uses CNT_W=4, SETTLE_CYCLES=3.
module tb_alu_cmd_sequencer;
  import alu_seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_sweep, rsp_ready;
  logic [7:0] cmd_a, cmd_b;
  logic [3:0] cmd_op;

  logic        cmd_ready, rsp_valid, rsp_carry, rsp_zero, rsp_last, busy, alu_carry;
  logic [7:0]  alu_a, alu_b, alu_out, rsp_result;
  logic [3:0]  alu_sel, rsp_op;
  logic [15:0] txn_count;

  logic       cmd_valid_w, rsp_ready_w;
  logic       cmd_ready_w, rsp_valid_w, rsp_carry_w, rsp_zero_w, rsp_last_w, busy_w, alu_carry_w;
  logic [7:0] alu_a_w, alu_b_w, alu_out_w, rsp_result_w;
  logic [3:0] alu_sel_w, rsp_op_w;
  logic [3:0] txn_count_w;

  int num_checks = 0;
  int num_fails  = 0;
  int exp_txn    = 0;

  // Behavioural ALU: {carry, result}
  function automatic logic [8:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                           input logic [3:0] sel);
    logic [15:0] p;
    logic [8:0]  r;
    p = 16'(a) * 16'(b);
    r = 9'h000;
    case (sel)
      OP_ADD:  r = {1'b0, a} + {1'b0, b};
      OP_SUB:  r = {1'b0, a} - {1'b0, b};
      OP_MUL:  r = {|p[15:8], p[7:0]};
      OP_DIV:  r = (b == 8'h00) ? 9'h1FF : {1'b0, a / b};
      OP_SHL:  r = {a[7], a[6:0], 1'b0};
      OP_SHR:  r = {a[0], 1'b0, a[7:1]};
      OP_ROL:  r = {1'b0, a[6:0], a[7]};
      OP_ROR:  r = {1'b0, a[0], a[7:1]};
      OP_AND:  r = {1'b0, a & b};
      OP_OR:   r = {1'b0, a | b};
      OP_XOR:  r = {1'b0, a ^ b};
      OP_NOR:  r = {1'b0, ~(a | b)};
      OP_NAND: r = {1'b0, ~(a & b)};
      OP_XNOR: r = {1'b0, ~(a ^ b)};
      OP_GT:   r = {8'h00, a > b};
      OP_EQ:   r = {8'h00, a == b};
      default: r = 9'h000;
    endcase
    return r;
  endfunction

  assign {alu_carry, alu_out}     = alu_model(alu_a, alu_b, alu_sel);
  assign {alu_carry_w, alu_out_w} = alu_model(alu_a_w, alu_b_w, alu_sel_w);

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.SETTLE_CYCLES(1), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_sweep(cmd_sweep),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_carry(alu_carry),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_carry(rsp_carry), .rsp_zero(rsp_zero),
    .rsp_op(rsp_op), .rsp_last(rsp_last),
    .busy(busy), .txn_count(txn_count)
  );

  alu_cmd_sequencer #(.SETTLE_CYCLES(3), .CNT_W(4)) dut_w (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid_w), .cmd_ready(cmd_ready_w),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_sweep(cmd_sweep),
    .alu_a(alu_a_w), .alu_b(alu_b_w), .alu_sel(alu_sel_w),
    .alu_out(alu_out_w), .alu_carry(alu_carry_w),
    .rsp_valid(rsp_valid_w), .rsp_ready(rsp_ready_w),
    .rsp_result(rsp_result_w), .rsp_carry(rsp_carry_w), .rsp_zero(rsp_zero_w),
    .rsp_op(rsp_op_w), .rsp_last(rsp_last_w),
    .busy(busy_w), .txn_count(txn_count_w)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    num_checks++;
    if (observed !== expected) begin
      num_fails++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Issue one command to dut; returns at the negedge right after the accepting edge
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                               input logic [3:0] op, input logic sweep);
    int n = 0;
    while (!cmd_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput("cmd_ready_seen", 32'(cmd_ready), 32'd1);
    cmd_a     = a;
    cmd_b     = b;
    cmd_op    = op;
    cmd_sweep = sweep;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic waitRsp(output int cycles);
    cycles = 0;
    while (!rsp_valid && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput("rsp_valid_seen", 32'(rsp_valid), 32'd1);
  endtask

  logic [7:0] sweep_exp [16] = '{8'h0C, 8'h08, 8'h14, 8'h05, 8'h14, 8'h05, 8'h14, 8'h05,
                                 8'h02, 8'h0A, 8'h08, 8'hF5, 8'hFD, 8'hF7, 8'h01, 8'h00};

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_sweep = 1'b0; rsp_ready = 1'b1;
    cmd_a = 8'h00; cmd_b = 8'h00; cmd_op = 4'h0;
    cmd_valid_w = 1'b0; rsp_ready_w = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_txn", 32'(txn_count), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_release_cmd_ready", 32'(cmd_ready), 32'd1);

    // Single ADD
    applyStimulus(8'h0A, 8'h02, OP_ADD, 1'b0);
    checkOutput("add_busy", 32'(busy), 32'd1);
    waitRsp(lat);
    checkOutput("add_latency", 32'(lat), 32'd2);
    checkOutput("add_result", 32'(rsp_result), 32'h0C);
    checkOutput("add_carry", 32'(rsp_carry), 32'd0);
    checkOutput("add_zero", 32'(rsp_zero), 32'd0);
    checkOutput("add_op", 32'(rsp_op), 32'd0);
    checkOutput("add_last", 32'(rsp_last), 32'd1);
    @(negedge clk);
    exp_txn++;
    checkOutput("add_txn", 32'(txn_count), 32'(exp_txn));
    checkOutput("add_ready_back", 32'(cmd_ready), 32'd1);

    // Carry and zero flags
    applyStimulus(8'hF6, 8'h0A, OP_ADD, 1'b0);
    waitRsp(lat);
    checkOutput("cz_result", 32'(rsp_result), 32'h00);
    checkOutput("cz_carry", 32'(rsp_carry), 32'd1);
    checkOutput("cz_zero", 32'(rsp_zero), 32'd1);
    @(negedge clk);
    exp_txn++;

    // Full sweep on 0x0A / 0x02
    applyStimulus(8'h0A, 8'h02, 4'h7, 1'b1);
    for (int i = 0; i < 16; i++) begin
      waitRsp(lat);
      if (i == 0) checkOutput("sweep_latency", 32'(lat), 32'd2);
      checkOutput($sformatf("sweep_op%0d", i), 32'(rsp_op), 32'(i));
      checkOutput($sformatf("sweep_result%0d", i), 32'(rsp_result), 32'(sweep_exp[i]));
      checkOutput($sformatf("sweep_last%0d", i), 32'(rsp_last), 32'(i == 15));
      checkOutput($sformatf("sweep_cmd_ready%0d", i), 32'(cmd_ready), 32'd0);
      @(negedge clk);
      exp_txn++;
    end
    checkOutput("sweep_txn", 32'(txn_count), 32'(exp_txn));
    checkOutput("sweep_done_busy", 32'(busy), 32'd0);

    // Backpressure: hold the response, pulse cmd_valid with other data
    rsp_ready = 1'b0;
    applyStimulus(8'h3C, 8'hC3, OP_OR, 1'b0);
    waitRsp(lat);
    checkOutput("bp_result", 32'(rsp_result), 32'hFF);
    for (int i = 0; i < 5; i++) begin
      cmd_valid = (i % 2 == 0);
      cmd_a     = 8'h55;
      cmd_op    = OP_AND;
      @(negedge clk);
      checkOutput($sformatf("bp_hold_valid%0d", i), 32'(rsp_valid), 32'd1);
      checkOutput($sformatf("bp_hold_result%0d", i), 32'(rsp_result), 32'hFF);
      checkOutput($sformatf("bp_hold_op%0d", i), 32'(rsp_op), 32'(OP_OR));
      checkOutput($sformatf("bp_busy%0d", i), 32'(busy), 32'd1);
      checkOutput($sformatf("bp_alu_a%0d", i), 32'(alu_a), 32'h3C);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    exp_txn++;
    checkOutput("bp_release_valid", 32'(rsp_valid), 32'd0);
    checkOutput("bp_txn", 32'(txn_count), 32'(exp_txn));
    checkOutput("bp_cmd_ready", 32'(cmd_ready), 32'd1);

    // Reset in the middle of a sweep, once op 7 is presented
    applyStimulus(8'h0A, 8'h02, OP_ADD, 1'b1);
    for (int i = 0; i < 16; i++) begin
      waitRsp(lat);
      if (rsp_op == OP_ROR) break;
      @(negedge clk);
    end
    checkOutput("mid_rst_op", 32'(rsp_op), 32'(OP_ROR));
    rst_n = 1'b0;
    @(negedge clk);
    exp_txn = 0;
    checkOutput("mid_rst_valid", 32'(rsp_valid), 32'd0);
    checkOutput("mid_rst_result", 32'(rsp_result), 32'd0);
    checkOutput("mid_rst_op_cleared", 32'(rsp_op), 32'd0);
    checkOutput("mid_rst_alu_a", 32'(alu_a), 32'd0);
    checkOutput("mid_rst_alu_sel", 32'(alu_sel), 32'd0);
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    checkOutput("mid_rst_cmd_ready", 32'(cmd_ready), 32'd0);
    checkOutput("mid_rst_txn", 32'(txn_count), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(8'h10, 8'h03, OP_SUB, 1'b0);
    waitRsp(lat);
    checkOutput("post_rst_latency", 32'(lat), 32'd2);
    checkOutput("post_rst_result", 32'(rsp_result), 32'h0D);
    checkOutput("post_rst_last", 32'(rsp_last), 32'd1);
    @(negedge clk);
    exp_txn++;
    checkOutput("post_rst_txn", 32'(txn_count), 32'(exp_txn));

    // Counter wrap and longer settle on the narrow instance
    for (int k = 1; k <= 17; k++) begin
      int n = 0;
      while (!cmd_ready_w && n < 40) begin
        @(negedge clk);
        n++;
      end
      checkOutput("w_cmd_ready_seen", 32'(cmd_ready_w), 32'd1);
      cmd_a       = 8'(k);
      cmd_b       = 8'h01;
      cmd_op      = OP_ADD;
      cmd_sweep   = 1'b0;
      cmd_valid_w = 1'b1;
      @(negedge clk);
      cmd_valid_w = 1'b0;
      lat = 0;
      while (!rsp_valid_w && lat < 40) begin
        @(negedge clk);
        lat++;
      end
      checkOutput($sformatf("w_latency%0d", k), 32'(lat), 32'd4);
      checkOutput($sformatf("w_result%0d", k), 32'(rsp_result_w), 32'(k + 1));
      @(negedge clk);
      checkOutput($sformatf("w_txn%0d", k), 32'(txn_count_w), 32'(k % 16));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
    $finish;
  end

endmodule
